// File: rtl/band_pkg.sv
// Shared constants and types for the band peak detector.
//   NUM_BANDS / IDX_W : band count and index width
//   DEF_DW / DEF_SW   : default band-energy and total-sum widths
//   state_e           : scan FSM states
package band_pkg;

  localparam int unsigned NUM_BANDS = 13;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned DEF_DW    = 31;
  localparam int unsigned DEF_SW    = 35;  // DEF_DW + 4 covers 13 bands without overflow

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DECIDE
  } state_e;

endpackage

// File: rtl/band_peak_detector_if.sv
// Frame input / result bundle of the band peak detector.
//   master : frame producer (drives in_en, din), observes results
//   slave  : detector (consumes in_en, din), drives out_en and result fields
interface band_peak_detector_if
  import band_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned SW = DEF_SW
) ();

  logic             in_en;
  logic [DW-1:0]    din [NUM_BANDS];
  logic             out_en;
  logic [IDX_W-1:0] peak_idx;
  logic [DW-1:0]    peak_val;
  logic [SW-1:0]    total;
  logic             frame_hit;
  logic             detect;
  logic             overrun;

  modport master (
    output in_en, din,
    input  out_en, peak_idx, peak_val, total, frame_hit, detect, overrun
  );

  modport slave (
    input  in_en, din,
    output out_en, peak_idx, peak_val, total, frame_hit, detect, overrun
  );

endinterface

// File: rtl/detect_hysteresis.sv
// Hit/miss hysteresis filter.
//   clk, rst : clock, synchronous active-high reset
//   upd      : one-cycle strobe, a new frame classification is present
//   hit      : classification of that frame
//   detect   : set after HIT_FRAMES consecutive hits, cleared after MISS_FRAMES consecutive misses
module detect_hysteresis #(
  parameter int unsigned HIT_FRAMES  = 3,
  parameter int unsigned MISS_FRAMES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic upd,
  input  logic hit,
  output logic detect
);

  localparam int unsigned HW = $clog2(HIT_FRAMES + 1);
  localparam int unsigned MW = $clog2(MISS_FRAMES + 1);

  logic [HW-1:0] hit_cnt_q;
  logic [MW-1:0] miss_cnt_q;
  logic          detect_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      detect_q   <= 1'b0;
    end else if (upd) begin
      if (hit) begin
        miss_cnt_q <= '0;
        if (hit_cnt_q != HW'(HIT_FRAMES)) hit_cnt_q <= hit_cnt_q + 1'b1;
        // Count reaches the threshold on this frame (or is already saturated there).
        if (hit_cnt_q >= HW'(HIT_FRAMES - 1)) detect_q <= 1'b1;
      end else begin
        hit_cnt_q <= '0;
        if (miss_cnt_q != MW'(MISS_FRAMES)) miss_cnt_q <= miss_cnt_q + 1'b1;
        if (miss_cnt_q >= MW'(MISS_FRAMES - 1)) detect_q <= 1'b0;
      end
    end
  end

  assign detect = detect_q;

endmodule

// File: rtl/band_peak_detector.sv
// Serial peak/total scanner over the 13 band energies of a frame, with
// spectral-dominance classification and hit/miss hysteresis.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of band_peak_detector_if (in_en/din in, results out)
// A frame accepted at edge E0 produces out_en in the cycle after edge E0+14.
// Frames offered while SCAN/DECIDE are busy are dropped and latch overrun.
module band_peak_detector
  import band_pkg::*;
#(
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned SW          = DEF_SW,
  parameter int unsigned BAND_LO     = 3,
  parameter int unsigned BAND_HI     = 9,
  parameter int unsigned RATIO_SHIFT = 2,
  parameter int unsigned MIN_ENERGY  = 1000,
  parameter int unsigned HIT_FRAMES  = 3,
  parameter int unsigned MISS_FRAMES = 2
) (
  input logic               clk,
  input logic               rst,
  band_peak_detector_if.slave bus
);

  localparam int unsigned CW = SW + RATIO_SHIFT;

  state_e           state_q;
  logic [DW-1:0]    band_buf_q [NUM_BANDS];
  logic [IDX_W-1:0] idx_q;
  logic [DW-1:0]    run_max_q;
  logic [IDX_W-1:0] run_idx_q;
  logic [SW-1:0]    run_sum_q;

  logic             out_en_q;
  logic [IDX_W-1:0] peak_idx_q;
  logic [DW-1:0]    peak_val_q;
  logic [SW-1:0]    total_q;
  logic             frame_hit_q;
  logic             overrun_q;

  logic [DW-1:0]    cur_band;
  logic [CW-1:0]    peak_scaled;
  logic [CW-1:0]    sum_ext;
  logic             hit_c;
  logic             detect;

  // Buffer only loads on an accepted frame, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.in_en) band_buf_q <= bus.din;
  end

  assign cur_band = band_buf_q[idx_q];

  // Dominance compare is done at SW+RATIO_SHIFT bits so the shifted peak never truncates.
  assign peak_scaled = CW'(run_max_q) << RATIO_SHIFT;
  assign sum_ext     = CW'(run_sum_q);
  assign hit_c       = (run_idx_q >= IDX_W'(BAND_LO)) && (run_idx_q <= IDX_W'(BAND_HI)) &&
                       (run_max_q >= DW'(MIN_ENERGY)) && (peak_scaled >= sum_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      run_sum_q   <= '0;
      out_en_q    <= 1'b0;
      peak_idx_q  <= '0;
      peak_val_q  <= '0;
      total_q     <= '0;
      frame_hit_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_en) begin
            idx_q     <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            run_sum_q <= '0;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          run_sum_q <= run_sum_q + SW'(cur_band);
          // Strict compare keeps the lowest index on ties.
          if (cur_band > run_max_q) begin
            run_max_q <= cur_band;
            run_idx_q <= idx_q;
          end
          if (idx_q == IDX_W'(NUM_BANDS - 1)) state_q <= DECIDE;
          else                                 idx_q   <= idx_q + 1'b1;
        end
        DECIDE: begin
          peak_idx_q  <= run_idx_q;
          peak_val_q  <= run_max_q;
          total_q     <= run_sum_q;
          frame_hit_q <= hit_c;
          out_en_q    <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (bus.in_en && state_q != IDLE) overrun_q <= 1'b1;
    end
  end

  detect_hysteresis #(
    .HIT_FRAMES (HIT_FRAMES),
    .MISS_FRAMES(MISS_FRAMES)
  ) u_hyst (
    .clk   (clk),
    .rst   (rst),
    .upd   (state_q == DECIDE),
    .hit   (hit_c),
    .detect(detect)
  );

  assign bus.out_en    = out_en_q;
  assign bus.peak_idx  = peak_idx_q;
  assign bus.peak_val  = peak_val_q;
  assign bus.total     = total_q;
  assign bus.frame_hit = frame_hit_q;
  assign bus.detect    = detect;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_band_peak_detector.sv
// Randomized self-checking bench for band_peak_detector with a behavioural reference model.
module tb_band_peak_detector;

  typedef logic [30:0] frame_t [13];

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference detection state: history of frame classifications since reset.
  bit hist[$];
  bit det_model = 1'b0;

  band_peak_detector_if bus ();

  band_peak_detector dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Peak = first maximum, total = plain sum, hit = dominance rule.
  function automatic void model(input frame_t f, output int pidx, output longint pval,
                                output longint tot, output bit hit);
    pidx = 0; pval = 0; tot = 0;
    for (int i = 0; i < 13; i++) begin
      tot += longint'(f[i]);
      if (longint'(f[i]) > pval) begin
        pval = longint'(f[i]);
        pidx = i;
      end
    end
    hit = (pidx >= 3) && (pidx <= 9) && (pval >= 1000) && (pval * 4 >= tot);
  endfunction

  // detect = 1 once the last 3 frames were hits, 0 once the last 2 were misses.
  function automatic void model_detect(input bit hit);
    int n;
    hist.push_back(hit);
    n = hist.size();
    if (n >= 3 && hist[n-1] && hist[n-2] && hist[n-3]) det_model = 1'b1;
    if (n >= 2 && !hist[n-1] && !hist[n-2]) det_model = 1'b0;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    det_model = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out_en"},    64'(bus.out_en), 0);
    check({tag, ".peak_idx"},  64'(bus.peak_idx), 0);
    check({tag, ".peak_val"},  64'(bus.peak_val), 0);
    check({tag, ".total"},     64'(bus.total), 0);
    check({tag, ".frame_hit"}, 64'(bus.frame_hit), 0);
    check({tag, ".detect"},    64'(bus.detect), 0);
    check({tag, ".overrun"},   64'(bus.overrun), 0);
  endtask

  // Called #1 after an edge; the pulse is sampled at the next edge.
  task automatic send(input frame_t f);
    bus.in_en = 1'b1;
    for (int i = 0; i < 13; i++) bus.din[i] = f[i];
    @(posedge clk); #1;
    bus.in_en = 1'b0;
    for (int i = 0; i < 13; i++) bus.din[i] = 31'($urandom);
  endtask

  task automatic wait_out(output bit seen, output int lat);
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (bus.out_en) begin
        seen = 1'b1;
        lat  = n;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (bus.out_en) cnt++;
    end
  endtask

  // Send one frame, wait for its result and compare every field with the model.
  task automatic run_frame(input string tag, input frame_t f, output bit hit);
    int pidx, lat;
    longint pval, tot;
    bit seen;
    model(f, pidx, pval, tot, hit);
    send(f);
    wait_out(seen, lat);
    check({tag, ".seen"}, 64'(seen), 1);
    if (seen) begin
      model_detect(hit);
      check({tag, ".latency"},   64'(lat), 14);
      check({tag, ".peak_idx"},  64'(bus.peak_idx), 64'(pidx));
      check({tag, ".peak_val"},  64'(bus.peak_val), 64'(pval));
      check({tag, ".total"},     64'(bus.total), 64'(tot));
      check({tag, ".frame_hit"}, 64'(bus.frame_hit), 64'(hit));
      check({tag, ".detect"},    64'(bus.detect), 64'(det_model));
      @(posedge clk); #1;
      check({tag, ".pulse_len"}, 64'(bus.out_en), 0);
    end
  endtask

  function automatic frame_t fill(input logic [30:0] v);
    frame_t f;
    for (int i = 0; i < 13; i++) f[i] = v;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    int kind, pk, pv;
    kind = $urandom_range(0, 9);
    if (kind < 6) begin
      pk = $urandom_range(0, 12);
      pv = $urandom_range(500, 200000);
      for (int i = 0; i < 13; i++) f[i] = 31'($urandom_range(0, pv / 6));
      f[pk] = 31'(pv);
      if (kind == 5) f[$urandom_range(0, 12)] = 31'(pv);  // possible tie
    end else if (kind < 8) begin
      for (int i = 0; i < 13; i++) f[i] = 31'($urandom_range(0, 999));
    end else begin
      for (int i = 0; i < 13; i++) f[i] = 31'($urandom);
    end
    return f;
  endfunction

  initial begin
    frame_t f;
    bit hit, seen;
    int cnt, lat;
    bit exp_det [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
    bit seq [8]     = '{1, 1, 0, 1, 1, 1, 0, 0};

    bus.in_en = 1'b0;
    for (int i = 0; i < 13; i++) bus.din[i] = '0;
    do_reset();
    check_zero("reset");

    f = fill(31'd100); f[5] = 31'd10000;
    run_frame("single", f, hit);
    check("single.hit_const", 64'(bus.frame_hit), 1);
    check("single.total_const", 64'(bus.total), 11200);

    f = fill(31'd0); f[4] = 31'd5000; f[7] = 31'd5000;
    run_frame("tie", f, hit);
    check("tie.idx_const", 64'(bus.peak_idx), 4);

    f = fill(31'd0); f[11] = 31'd9000;
    run_frame("out_of_band", f, hit);
    f = fill(31'd1000); f[5] = 31'd2000;
    run_frame("not_dominant", f, hit);
    f = fill(31'd0); f[5] = 31'd900;
    run_frame("below_floor", f, hit);
    f = fill(31'd0);
    run_frame("all_zero", f, hit);

    // Hysteresis sequence from a clean reset.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (seq[k]) begin f = fill(31'd100); f[5] = 31'd10000; end
      else begin f = fill(31'd0); f[11] = 31'd9000; end
      run_frame($sformatf("hyst%0d", k), f, hit);
      check($sformatf("hyst%0d.det_const", k), 64'(bus.detect), 64'(exp_det[k]));
    end

    // Overrun: second frame 5 cycles after the first is dropped.
    do_reset();
    f = fill(31'd100); f[6] = 31'd7000;
    begin
      int pidx;
      longint pval, tot;
      frame_t g;
      model(f, pidx, pval, tot, hit);
      send(f);
      repeat (4) @(posedge clk);
      #1;
      g = fill(31'd50); g[2] = 31'd90000;
      send(g);
      wait_out(seen, lat);
      check("ovr.seen", 64'(seen), 1);
      check("ovr.latency", 64'(lat), 9);
      check("ovr.peak_idx", 64'(bus.peak_idx), 64'(pidx));
      check("ovr.total", 64'(bus.total), 64'(tot));
      check("ovr.overrun", 64'(bus.overrun), 1);
      count_pulses(30, cnt);
      check("ovr.extra_pulses", 64'(cnt), 0);
      check("ovr.sticky", 64'(bus.overrun), 1);
    end
    do_reset();
    check_zero("ovr_reset");

    // Reset mid-scan abandons the frame.
    f = fill(31'd100); f[5] = 31'd10000;
    send(f);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hist.delete();
    det_model = 1'b0;
    count_pulses(25, cnt);
    check("midscan.pulses", 64'(cnt), 0);
    check_zero("midscan");
    f = fill(31'h7fffffff);
    run_frame("all_max", f, hit);
    check("all_max.total_const", 64'(bus.total), 64'd27917287411);
    check("all_max.idx_const", 64'(bus.peak_idx), 0);

    // Randomized frames, back-to-back and with idle gaps.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      f = rand_frame();
      run_frame($sformatf("rand%0d", k), f, hit);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    check("rand.no_overrun", 64'(bus.overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
